// File: rtl/scoreboard_pkg.sv
// Shared types and constants for the shot-clock scoreboard: game states,
// made_shot encodings and the point value of each shot outcome.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  localparam logic [1:0] MS_MISS  = 2'd0;
  localparam logic [1:0] MS_TWO   = 2'd1;
  localparam logic [1:0] MS_THREE = 2'd2;
  localparam logic [1:0] MS_FT    = 2'd3;

  localparam logic [7:0] PTS_MISS  = 8'd0;
  localparam logic [7:0] PTS_FT    = 8'd1;
  localparam logic [7:0] PTS_TWO   = 8'd2;
  localparam logic [7:0] PTS_THREE = 8'd3;

  // Points for a shot outcome, already widened for the 8-bit score add.
  function automatic logic [7:0] shot_points(input logic [1:0] made_shot);
    logic [7:0] pts;
    case (made_shot)
      MS_MISS:  pts = PTS_MISS;
      MS_TWO:   pts = PTS_TWO;
      MS_THREE: pts = PTS_THREE;
      MS_FT:    pts = PTS_FT;
      default:  pts = PTS_MISS;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-flop rising-edge detector. The history flop reset value is chosen so
// that an input already high when reset releases does not produce an event.
module rise_detect #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic q_r;

  // History of the input from the previous clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r <= RESET_VAL;
    end else begin
      q_r <= in;
    end
  end

  assign rise = in & ~q_r;

endmodule

// File: rtl/shot_clock_scoreboard.sv
// Shot clock and saturating score keeper with the IDLE/RUN/EXPIRED game FSM;
// all game state and outputs are registered in the clk domain.
module shot_clock_scoreboard
  import scoreboard_pkg::*;
#(
  parameter int FRAMES_PER_SEC  = 60,
  parameter int SHOT_CLOCK_INIT = 24,
  parameter int SCORE_MAX       = 99
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       start,
  input  logic       shot_finished,
  input  logic [1:0] made_shot,
  output logic [4:0] timer,
  output logic [6:0] score,
  output logic       running,
  output logic       expired,
  output logic       buzzer
);

  localparam logic [4:0] TIMER_INIT = 5'(SHOT_CLOCK_INIT);
  localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_SEC - 1);
  localparam logic [7:0] SCORE_CAP  = 8'(SCORE_MAX);

  logic vsync_ev_s, start_ev_s, shot_ev_s;

  rise_detect #(.RESET_VAL(1'b1)) u_vsync_rise (
    .clk(clk), .reset(reset), .in(vsync), .rise(vsync_ev_s)
  );
  rise_detect #(.RESET_VAL(1'b1)) u_start_rise (
    .clk(clk), .reset(reset), .in(start), .rise(start_ev_s)
  );
  rise_detect #(.RESET_VAL(1'b1)) u_shot_rise (
    .clk(clk), .reset(reset), .in(shot_finished), .rise(shot_ev_s)
  );

  state_t     state_r, state_s;
  logic [5:0] frame_cnt_r, frame_cnt_s;
  logic [4:0] timer_r, timer_s;
  logic [6:0] score_r, score_s;
  logic       buzzer_r, buzzer_s;
  logic [7:0] score_sum_s;

  assign score_sum_s = {1'b0, score_r} + shot_points(made_shot);

  // Next-state and next-output logic for the game FSM.
  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    timer_s     = timer_r;
    score_s     = score_r;
    buzzer_s    = 1'b0;
    case (state_r)
      IDLE, EXPIRED: begin
        timer_s = (state_r == IDLE) ? TIMER_INIT : 5'd0;
        if (start_ev_s) begin
          state_s     = RUN;
          score_s     = 7'd0;
          frame_cnt_s = 6'd0;
          timer_s     = TIMER_INIT;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        // A shot takes priority over a same-cycle expiry tick.
        if (shot_ev_s) begin
          score_s     = (score_sum_s > SCORE_CAP) ? SCORE_CAP[6:0] : score_sum_s[6:0];
          timer_s     = TIMER_INIT;
          frame_cnt_s = 6'd0;
        end else if (vsync_ev_s) begin
          if (frame_cnt_r == FRAME_LAST) begin
            frame_cnt_s = 6'd0;
            if (timer_r == 5'd1) begin
              timer_s  = 5'd0;
              state_s  = EXPIRED;
              buzzer_s = 1'b1;
            end else begin
              timer_s = timer_r - 5'd1;
            end
          end else begin
            frame_cnt_s = frame_cnt_r + 6'd1;
          end
        end else begin
          frame_cnt_s = frame_cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        timer_s = TIMER_INIT;
      end
    endcase
  end

  // Game state and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      frame_cnt_r <= 6'd0;
      timer_r     <= TIMER_INIT;
      score_r     <= 7'd0;
      buzzer_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      frame_cnt_r <= frame_cnt_s;
      timer_r     <= timer_s;
      score_r     <= score_s;
      buzzer_r    <= buzzer_s;
    end
  end

  assign timer   = timer_r;
  assign score   = score_r;
  assign buzzer  = buzzer_r;
  assign running = (state_r == RUN);
  assign expired = (state_r == EXPIRED);

endmodule

// File: tb/tb_shot_clock_scoreboard.sv
// Directed self-checking bench for shot_clock_scoreboard with hand-computed
// expected values for countdown, scoring, saturation, expiry and reset.
module tb_shot_clock_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       vsync;
  logic       start;
  logic       shot_finished;
  logic [1:0] made_shot;
  logic [4:0] timer;
  logic [6:0] score;
  logic       running;
  logic       expired;
  logic       buzzer;

  int errors = 0;
  int checks = 0;

  shot_clock_scoreboard dut (
    .clk(clk), .reset(reset), .vsync(vsync), .start(start),
    .shot_finished(shot_finished), .made_shot(made_shot),
    .timer(timer), .score(score), .running(running),
    .expired(expired), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      tick();
      vsync = 1'b1;
      tick();
    end
  endtask

  task automatic shot(input logic [1:0] ms);
    made_shot = ms;
    shot_finished = 1'b1;
    tick();
    shot_finished = 1'b0;
    tick();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    vsync = 1'b1;
    start = 1'b1;
    shot_finished = 1'b1;
    made_shot = 2'd1;
    tick();
    tick();
    chk("reset_timer", timer, 24);
    chk("reset_score", score, 0);
    chk("reset_running", running, 0);
    chk("reset_buzzer", buzzer, 0);
    reset = 1'b0;
    tick();
    tick();
    chk("held_high_running", running, 0);
    chk("held_high_timer", timer, 24);
    chk("held_high_score", score, 0);
    start = 1'b0;
    shot_finished = 1'b0;
    tick();

    start_pulse();
    chk("start_running", running, 1);
    chk("start_timer", timer, 24);
    frames(59);
    chk("59_frames_timer", timer, 24);
    frames(1);
    chk("60_frames_timer", timer, 23);
    frames(13 * 60);
    chk("countdown_to_10", timer, 10);

    shot(2'd2);
    chk("three_pt_score", score, 3);
    chk("three_pt_reload", timer, 24);
    frames(30);
    shot(2'd0);
    chk("miss_score", score, 3);
    chk("miss_reload", timer, 24);
    frames(59);
    chk("frame_cleared_59", timer, 24);
    frames(1);
    chk("frame_cleared_60", timer, 23);

    for (int i = 0; i < 31; i++) shot(2'd2);
    chk("score_96", score, 96);
    shot(2'd3);
    shot(2'd3);
    chk("free_throws_98", score, 98);
    start_pulse();
    chk("start_ignored_in_run", score, 98);
    shot(2'd2);
    chk("sat_99", score, 99);
    shot(2'd1);
    chk("sat_stays_99", score, 99);

    frames(23 * 60 + 59);
    chk("timer_at_1", timer, 1);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    shot_finished = 1'b1;
    made_shot = 2'd0;
    tick();
    chk("simul_timer", timer, 24);
    chk("simul_buzzer", buzzer, 0);
    chk("simul_running", running, 1);
    shot_finished = 1'b0;
    tick();
    chk("simul_buzzer_later", buzzer, 0);

    frames(24 * 60 - 1);
    chk("pre_expiry_timer", timer, 1);
    vsync = 1'b0;
    tick();
    chk("pre_expiry_buzzer", buzzer, 0);
    vsync = 1'b1;
    tick();
    chk("expiry_timer", timer, 0);
    chk("expiry_expired", expired, 1);
    chk("expiry_running", running, 0);
    chk("expiry_buzzer", buzzer, 1);
    tick();
    chk("buzzer_one_cycle", buzzer, 0);

    shot(2'd2);
    chk("expired_shot_score", score, 99);
    chk("expired_shot_timer", timer, 0);
    frames(60);
    chk("expired_timer_hold", timer, 0);
    chk("expired_stays", expired, 1);

    made_shot = 2'd2;
    start = 1'b1;
    shot_finished = 1'b1;
    tick();
    chk("restart_score", score, 0);
    chk("restart_timer", timer, 24);
    chk("restart_running", running, 1);
    chk("restart_expired", expired, 0);
    start = 1'b0;
    shot_finished = 1'b0;
    tick();

    shot(2'd1);
    frames(70);
    chk("pre_reset_score", score, 2);
    chk("pre_reset_timer", timer, 23);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_timer", timer, 24);
    chk("async_reset_score", score, 0);
    chk("async_reset_running", running, 0);
    tick();
    reset = 1'b0;
    frames(60);
    chk("no_resume_running", running, 0);
    chk("no_resume_timer", timer, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
